// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and widths for the data-memory port arbiter.
//   arb_state_e : arbiter FSM state (IDLE, LDR_BURST)
//   owner_e     : which side drives data_mem this cycle
//   WAIT_W      : width of the loader wait / burst beat counters
//   CNT_W       : width of the optional statistics counters
package dmem_arb_pkg;
  localparam int WAIT_W = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LDR_BURST = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_LDR  = 2'd2
  } owner_e;

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction
endpackage

// File: rtl/dmem_arb_mux.sv
// dmem_arb_mux: combinational select of the data_mem request from the owning side.
// Ports:
//   owner                      : current port owner (none/core/loader)
//   core_rd_en/wr_en/addr/wdata: LSU request; write wins if both enables set
//   ldr_we/addr/wdata          : loader beat
//   mem_rd_en/wr_en/addr/wr_data: request to data_mem; enables low when nobody owns
module dmem_arb_mux
  import dmem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  owner_e          owner,
  input  logic            core_rd_en,
  input  logic            core_wr_en,
  input  logic [AW-1:0]   core_addr,
  input  logic [DW-1:0]   core_wdata,
  input  logic            ldr_we,
  input  logic [AW-1:0]   ldr_addr,
  input  logic [DW-1:0]   ldr_wdata,
  output logic            mem_rd_en,
  output logic            mem_wr_en,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wr_data
);
  always_comb begin
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = core_addr;
    mem_wr_data = core_wdata;
    case (owner)
      OWN_CORE: begin
        mem_wr_en = core_wr_en;
        mem_rd_en = core_rd_en & ~core_wr_en;
      end
      OWN_LDR: begin
        mem_wr_en   = ldr_we;
        mem_rd_en   = ~ldr_we;
        mem_addr    = ldr_addr;
        mem_wr_data = ldr_wdata;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data_mem port between the LSU and the UART loader.
// Core has fixed priority; a loader starved for MAX_WAIT cycles is forced one grant, and a
// locked loader may hold the port for up to BURST_MAX consecutive beats. Grants are
// combinational in the request cycle; the core sees core_stall when it loses.
// Ports: clk, rst (sync, active-high); core_* (LSU side, core_rdata/core_stall out);
//   ldr_* (loader side, ldr_gnt/ldr_rdata out); mem_* (data_mem side, mem_rdata in).
// Optional: define DMEM_ARB_STATS_EN to add conflict_cnt (stalled-core cycles) and
//   forced_cnt (starvation-forced loader grants), 16-bit saturating.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT  = 8,
  parameter int BURST_MAX = 4,
  parameter int AW        = 32,
  parameter int DW        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             core_rd_en,
  input  logic             core_wr_en,
  input  logic [AW-1:0]    core_addr,
  input  logic [DW-1:0]    core_wdata,
  output logic [DW-1:0]    core_rdata,
  output logic             core_stall,
  input  logic             ldr_req,
  input  logic             ldr_we,
  input  logic             ldr_lock,
  input  logic [AW-1:0]    ldr_addr,
  input  logic [DW-1:0]    ldr_wdata,
  output logic             ldr_gnt,
  output logic [DW-1:0]    ldr_rdata,
  output logic             mem_rd_en,
  output logic             mem_wr_en,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wr_data,
  input  logic [DW-1:0]    mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic [CNT_W-1:0] forced_cnt
`endif
);
  localparam logic [WAIT_W-1:0] MAX_W   = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] BURST_W = WAIT_W'(BURST_MAX);

  arb_state_e        state, state_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_nx;
  logic [WAIT_W-1:0] beat_cnt, beat_nx;
  owner_e            owner;
  logic              core_req;
  logic              forced;

  assign core_req   = core_rd_en | core_wr_en;
  assign core_rdata = mem_rdata;
  assign ldr_rdata  = mem_rdata;

  always_comb begin
    owner      = OWN_NONE;
    ldr_gnt    = 1'b0;
    core_stall = 1'b0;
    forced     = 1'b0;
    state_nx   = state;
    beat_nx    = beat_cnt;
    // Reset overrides everything so an in-flight burst never touches memory.
    if (!rst) begin
      case (state)
        IDLE: begin
          beat_nx = '0;
          // A wait_cnt at MAX_WAIT only matters while the loader is still asking.
          if (core_req && (wait_cnt < MAX_W || !ldr_req)) begin
            owner = OWN_CORE;
          end else if (ldr_req) begin
            owner      = OWN_LDR;
            ldr_gnt    = 1'b1;
            core_stall = core_req;
            forced     = core_req;
            if (ldr_lock && BURST_MAX > 1) begin
              state_nx = LDR_BURST;
              beat_nx  = WAIT_W'(1);
            end
          end
        end
        LDR_BURST: begin
          core_stall = core_req;
          state_nx   = IDLE;
          beat_nx    = '0;
          if (ldr_req) begin
            owner   = OWN_LDR;
            ldr_gnt = 1'b1;
            // An unlocked beat is still served but ends the burst.
            if (ldr_lock && (beat_cnt + WAIT_W'(1)) != BURST_W) begin
              state_nx = LDR_BURST;
              beat_nx  = beat_cnt + WAIT_W'(1);
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    if (!ldr_req || ldr_gnt) wait_nx = '0;
    else if (wait_cnt < MAX_W) wait_nx = wait_cnt + WAIT_W'(1);
    else                       wait_nx = wait_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      beat_cnt <= beat_nx;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
      forced_cnt   <= '0;
    end else begin
      if (core_stall) conflict_cnt <= sat_inc_cnt(conflict_cnt);
      if (forced)     forced_cnt   <= sat_inc_cnt(forced_cnt);
    end
  end
`endif

  dmem_arb_mux #(.AW(AW), .DW(DW)) u_mux (
    .owner       (owner),
    .core_rd_en  (core_rd_en),
    .core_wr_en  (core_wr_en),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .ldr_we      (ldr_we),
    .ldr_addr    (ldr_addr),
    .ldr_wdata   (ldr_wdata),
    .mem_rd_en   (mem_rd_en),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data)
  );
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus randomized traffic checked against
// a cycle-level reference model of the arbitration rules. Inputs change 1ns after the
// rising edge; outputs are sampled on the falling edge.
module tb_dmem_port_arbiter;
  localparam int MAX_WAIT  = 8;
  localparam int BURST_MAX = 4;

  logic        clk, rst;
  logic        core_rd_en, core_wr_en;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_stall;
  logic        ldr_req, ldr_we, ldr_lock;
  logic [31:0] ldr_addr, ldr_wdata, ldr_rdata;
  logic        ldr_gnt;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_addr, mem_wr_data, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_cnt, forced_cnt;
`endif

  dmem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .core_rd_en(core_rd_en), .core_wr_en(core_wr_en), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_lock(ldr_lock), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt), .ldr_rdata(ldr_rdata),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt), .forced_cnt(forced_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Environment memory: 64 words, combinational read, written on the clock edge.
  logic [31:0] tb_mem [0:63];
  bit          mem_ready;
  assign mem_rdata = tb_mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= 32'h1000_0000 + i * 32'h0101;
      mem_ready <= 1'b1;
    end else if (mem_wr_en) begin
      tb_mem[mem_addr[7:2]] <= mem_wr_data;
    end
  end

  int n_pass, n_total;

  // Reference model state: loader wait length, beats taken in the current burst (0 = no
  // burst), memory image and statistics.
  int          m_wait, m_beats, m_conf, m_forced;
  int          n_wait, n_beats, n_conf, n_forced;
  logic [31:0] m_mem [0:63];
  logic        exp_gnt, exp_stall, exp_rd, exp_wr;
  logic [31:0] exp_addr, exp_wdata;

  task automatic model_eval();
    bit creq, cwin, lwin;
    creq = core_rd_en | core_wr_en;
    cwin = 0; lwin = 0;
    exp_gnt = 0; exp_stall = 0; exp_rd = 0; exp_wr = 0; exp_addr = '0; exp_wdata = '0;
    if (rst) begin
      n_wait = 0; n_beats = 0; n_conf = 0; n_forced = 0;
    end else begin
      if (m_beats > 0) begin
        lwin      = ldr_req;
        exp_stall = creq;
        n_beats   = (ldr_req && ldr_lock && m_beats + 1 < BURST_MAX) ? m_beats + 1 : 0;
      end else begin
        cwin      = creq && (m_wait < MAX_WAIT || !ldr_req);
        lwin      = !cwin && ldr_req;
        exp_stall = creq && !cwin;
        n_beats   = (lwin && ldr_lock && BURST_MAX > 1) ? 1 : 0;
      end
      if (cwin) begin
        exp_wr = core_wr_en; exp_rd = !core_wr_en; exp_addr = core_addr; exp_wdata = core_wdata;
      end else if (lwin) begin
        exp_gnt = 1; exp_wr = ldr_we; exp_rd = !ldr_we; exp_addr = ldr_addr; exp_wdata = ldr_wdata;
      end
      n_wait   = (!ldr_req || lwin) ? 0 : (m_wait < MAX_WAIT ? m_wait + 1 : MAX_WAIT);
      n_conf   = (exp_stall && m_conf < 65535) ? m_conf + 1 : m_conf;
      n_forced = (lwin && creq && m_beats == 0 && m_forced < 65535) ? m_forced + 1 : m_forced;
    end
  endtask

  task automatic advance();
    if (exp_wr) m_mem[exp_addr[7:2]] = exp_wdata;
    m_wait = n_wait; m_beats = n_beats; m_conf = n_conf; m_forced = n_forced;
    @(posedge clk); #1;
  endtask

  task automatic zero_inputs();
    core_rd_en = 0; core_wr_en = 0; core_addr = '0; core_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_lock = 0; ldr_addr = '0; ldr_wdata = '0;
  endtask

  task automatic quiet();
    zero_inputs(); rst = 0;
    @(negedge clk); model_eval(); advance();
  endtask

  task automatic do_reset();
    zero_inputs(); rst = 1;
    @(negedge clk); model_eval(); advance();
    rst = 0;
  endtask

  task automatic test_reset();
    zero_inputs(); rst = 1;
    core_rd_en = 1; core_addr = 32'h10; ldr_req = 1; ldr_we = 1; ldr_addr = 32'h20;
    @(negedge clk); model_eval();
    n_total++;
    if ({ldr_gnt, core_stall, mem_rd_en, mem_wr_en} !== 4'b0000)
      $display("FAIL reset_outputs: got gnt/stall/rd/wr=%b want 0000",
               {ldr_gnt, core_stall, mem_rd_en, mem_wr_en});
    else n_pass++;
    advance();
    rst = 0; zero_inputs();
  endtask

  task automatic test_core_only();
    zero_inputs(); core_rd_en = 1; core_addr = 32'h10;
    @(negedge clk); model_eval();
    n_total++;
    if ({mem_rd_en, mem_wr_en, core_stall, ldr_gnt} !== 4'b1000 || mem_addr !== 32'h10)
      $display("FAIL core_read: got rd/wr/stall/gnt=%b addr=%h want 1000 addr=00000010",
               {mem_rd_en, mem_wr_en, core_stall, ldr_gnt}, mem_addr);
    else n_pass++;
    n_total++;
    if (core_rdata !== 32'h1000_0404)
      $display("FAIL core_rdata: got %h want 10000404", core_rdata);
    else n_pass++;
    advance();
    quiet();
  endtask

  // Core and loader both request every cycle; loader is forced in on cycle MAX_WAIT+1.
  task automatic test_starvation();
    do_reset();
    for (int c = 1; c <= MAX_WAIT + 1; c++) begin
      zero_inputs();
      core_rd_en = 1; core_addr = 32'h30;
      ldr_req = 1; ldr_we = 1; ldr_addr = 32'h34; ldr_wdata = 32'hCAFE_0001;
      @(negedge clk); model_eval();
      n_total++;
      if (c <= MAX_WAIT) begin
        if ({ldr_gnt, core_stall, mem_rd_en} !== 3'b001)
          $display("FAIL starve_core_win c=%0d: got gnt/stall/rd=%b want 001", c,
                   {ldr_gnt, core_stall, mem_rd_en});
        else n_pass++;
      end else begin
        if ({ldr_gnt, core_stall, mem_wr_en, mem_rd_en} !== 4'b1110 || mem_addr !== 32'h34)
          $display("FAIL starve_forced: got gnt/stall/wr/rd=%b addr=%h want 1110 addr=34",
                   {ldr_gnt, core_stall, mem_wr_en, mem_rd_en}, mem_addr);
        else n_pass++;
      end
      advance();
    end
`ifdef DMEM_ARB_STATS_EN
    @(negedge clk);
    n_total++;
    if (conflict_cnt !== 16'd1 || forced_cnt !== 16'd1)
      $display("FAIL stats_starve: got conflict=%0d forced=%0d want 1 1", conflict_cnt, forced_cnt);
    else n_pass++;
    @(posedge clk); #1;
`endif
    quiet();
  endtask

  // Six locked loader writes; core starts asking on cycle 2 and is locked out until 5.
  task automatic test_burst();
    logic [7:0] g_exp, s_exp;
    int k;
    g_exp = 8'b0110_1111;
    s_exp = 8'b0000_1110;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      zero_inputs();
      ldr_req = (k < 6); ldr_we = 1; ldr_lock = (k < 6);
      ldr_addr = 32'h40 + 32'(k) * 4; ldr_wdata = 32'h1000 + 32'(k);
      if (c >= 1 && c <= 4) begin
        core_wr_en = 1; core_addr = 32'h80; core_wdata = 32'hC0DE;
      end
      @(negedge clk); model_eval();
      n_total++;
      if (ldr_gnt !== g_exp[c] || core_stall !== s_exp[c])
        $display("FAIL burst_grant c=%0d: got gnt=%b stall=%b want gnt=%b stall=%b",
                 c + 1, ldr_gnt, core_stall, g_exp[c], s_exp[c]);
      else n_pass++;
      if (g_exp[c]) begin
        n_total++;
        if (mem_wr_en !== 1'b1 || mem_wr_data !== 32'h1000 + 32'(k))
          $display("FAIL burst_data c=%0d: got wr=%b data=%h want 1 %h", c + 1, mem_wr_en,
                   mem_wr_data, 32'h1000 + 32'(k));
        else n_pass++;
      end
      if (ldr_gnt) k++;
      advance();
    end
    quiet();
  endtask

  task automatic test_ldr_read();
    zero_inputs(); ldr_req = 1; ldr_we = 1; ldr_addr = 32'h20; ldr_wdata = 32'hDEAD_BEEF;
    @(negedge clk); model_eval();
    n_total++;
    if (ldr_gnt !== 1'b1 || mem_wr_en !== 1'b1)
      $display("FAIL ldr_write: got gnt=%b wr=%b want 1 1", ldr_gnt, mem_wr_en);
    else n_pass++;
    advance();
    ldr_we = 0;
    @(negedge clk); model_eval();
    n_total++;
    if (ldr_gnt !== 1'b1 || mem_rd_en !== 1'b1 || ldr_rdata !== 32'hDEAD_BEEF)
      $display("FAIL ldr_read: got gnt=%b rd=%b rdata=%h want 1 1 deadbeef", ldr_gnt,
               mem_rd_en, ldr_rdata);
    else n_pass++;
    advance();
    quiet();
  endtask

  task automatic test_reset_mid_burst();
    zero_inputs(); ldr_req = 1; ldr_we = 1; ldr_lock = 1; ldr_addr = 32'h50; ldr_wdata = 32'h5;
    @(negedge clk); model_eval();
    n_total++;
    if (ldr_gnt !== 1'b1)
      $display("FAIL midrst_beat1: got gnt=%b want 1", ldr_gnt);
    else n_pass++;
    advance();
    rst = 1; ldr_addr = 32'h54; core_rd_en = 1; core_addr = 32'h60;
    @(negedge clk); model_eval();
    n_total++;
    if ({ldr_gnt, core_stall, mem_rd_en, mem_wr_en} !== 4'b0000)
      $display("FAIL midrst_abort: got gnt/stall/rd/wr=%b want 0000",
               {ldr_gnt, core_stall, mem_rd_en, mem_wr_en});
    else n_pass++;
    advance();
    rst = 0;
    // Back in IDLE with an empty wait count: core wins exactly MAX_WAIT times.
    for (int i = 0; i <= MAX_WAIT; i++) begin
      @(negedge clk); model_eval();
      n_total++;
      if (ldr_gnt !== (i == MAX_WAIT) || core_stall !== (i == MAX_WAIT))
        $display("FAIL midrst_after i=%0d: got gnt=%b stall=%b want %b %b", i, ldr_gnt,
                 core_stall, i == MAX_WAIT, i == MAX_WAIT);
      else n_pass++;
      advance();
    end
    quiet();
  endtask

  task automatic test_random();
    bit core_hold, ldr_pend;
    int r, errs;
    core_hold = 0; ldr_pend = 0; errs = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (!core_hold) begin
        r = $urandom_range(0, 7);
        core_rd_en = (r == 1 || r == 2 || r == 7);
        core_wr_en = (r == 3 || r == 4 || r == 7);
        core_addr  = {24'h0, 6'($urandom), 2'b00};
        core_wdata = $urandom;
      end
      if (!ldr_pend) begin
        ldr_req   = ($urandom_range(0, 2) != 0);
        ldr_we    = $urandom_range(0, 1) == 1;
        ldr_addr  = {24'h0, 6'($urandom), 2'b00};
        ldr_wdata = $urandom;
      end
      ldr_lock = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 60) == 0);
      @(negedge clk); model_eval();
      n_total++;
      if ({ldr_gnt, core_stall, mem_rd_en, mem_wr_en} !== {exp_gnt, exp_stall, exp_rd, exp_wr}) begin
        if (errs < 10) $display("FAIL rand_ctrl c=%0d: got gnt/stall/rd/wr=%b want %b", c,
                                {ldr_gnt, core_stall, mem_rd_en, mem_wr_en},
                                {exp_gnt, exp_stall, exp_rd, exp_wr});
        errs++;
      end else n_pass++;
      if (exp_rd || exp_wr) begin
        n_total++;
        if (mem_addr !== exp_addr || (exp_wr && mem_wr_data !== exp_wdata)) begin
          if (errs < 10) $display("FAIL rand_req c=%0d: got addr=%h data=%h want %h %h", c,
                                  mem_addr, mem_wr_data, exp_addr, exp_wdata);
          errs++;
        end else n_pass++;
      end
      if (exp_rd) begin
        n_total++;
        if ((exp_gnt ? ldr_rdata : core_rdata) !== m_mem[exp_addr[7:2]]) begin
          if (errs < 10) $display("FAIL rand_rdata c=%0d: got %h want %h", c,
                                  exp_gnt ? ldr_rdata : core_rdata, m_mem[exp_addr[7:2]]);
          errs++;
        end else n_pass++;
      end
`ifdef DMEM_ARB_STATS_EN
      n_total++;
      if (conflict_cnt !== 16'(m_conf) || forced_cnt !== 16'(m_forced)) begin
        if (errs < 10) $display("FAIL rand_stats c=%0d: got %0d %0d want %0d %0d", c,
                                conflict_cnt, forced_cnt, m_conf, m_forced);
        errs++;
      end else n_pass++;
`endif
      core_hold = core_stall;
      ldr_pend  = ldr_req && !ldr_gnt;
      advance();
    end
    rst = 0;
    quiet();
  endtask

  initial begin
    clk = 0; rst = 0; n_pass = 0; n_total = 0;
    m_wait = 0; m_beats = 0; m_conf = 0; m_forced = 0;
    for (int i = 0; i < 64; i++) m_mem[i] = 32'h1000_0000 + i * 32'h0101;
    zero_inputs();
    @(posedge clk); #1;
    test_reset();
    test_core_only();
    test_starvation();
    test_burst();
    test_ldr_read();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
